w_update_bank: RTL

W_UPDATE_BANK -- requirements
Module: w_update_bank

---
 rtl/w_update_pkg.sv | 20 ++
 rtl/w_update_bank_if.sv | 25 ++
 rtl/w_update_mac.sv | 59 +++++
 rtl/w_update_bank.sv | 139 +++++++++++++
 4 files changed

// File: rtl/w_update_pkg.sv
// Shared types and constants for the weight-update bank: FSM encoding,
// default geometry and the fixed-point rounding offset.
package w_update_pkg;

    localparam int unsigned W_DEF_WIDTH = 16;
    localparam int unsigned W_DEF_QP    = 12;
    localparam int unsigned W_DEF_TAPS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } w_state_e;

    // Half an output LSB, added before truncation for round-half-up.
    function automatic logic [63:0] round_offset(input int unsigned qp);
        round_offset = (qp == 0) ? 64'd0 : (64'd1 << (qp - 1));
    endfunction

endpackage

// File: rtl/w_update_bank_if.sv
// Request/status bundle for w_update_bank: start, captured operands, busy/done
// status and the packed weight vector.
interface w_update_bank_if
    import w_update_pkg::*;
#(
    parameter int unsigned WIDTH = W_DEF_WIDTH,
    parameter int unsigned TAPS  = W_DEF_TAPS
);
    logic                    start;
    logic [WIDTH-1:0]        mu_error;
    logic [TAPS*WIDTH-1:0]   x_vec;
    logic                    busy;
    logic                    done;
    logic [TAPS*WIDTH-1:0]   w_out;

    modport master (
        output start, mu_error, x_vec,
        input  busy, done, w_out
    );

    modport slave (
        input  start, mu_error, x_vec,
        output busy, done, w_out
    );
endinterface

// File: rtl/w_update_mac.sv
// One signed multiply per cycle: x * mu, round-half-up, slice back to WIDTH
// bits, then a single pipeline register carrying the term and its tap index.
module w_update_mac
    import w_update_pkg::*;
#(
    parameter int unsigned WIDTH = W_DEF_WIDTH,
    parameter int unsigned QP    = W_DEF_QP,
    parameter int unsigned IDXW  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en_i,
    input  logic [IDXW-1:0]         idx_i,
    input  logic signed [WIDTH-1:0] x_i,
    input  logic signed [WIDTH-1:0] mu_i,
    output logic                    valid_o,
    output logic [IDXW-1:0]         idx_o,
    output logic signed [WIDTH-1:0] term_o
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [PW-1:0] RND = PW'(round_offset(QP));

    logic signed [PW-1:0]    x_ext;
    logic signed [PW-1:0]    mu_ext;
    logic signed [PW-1:0]    prod;
    logic [PW-1:0]           rounded;
    logic signed [WIDTH-1:0] term_d;

    logic                    valid_q;
    logic [IDXW-1:0]         idx_q;
    logic signed [WIDTH-1:0] term_q;

    always_comb begin
        x_ext   = {{WIDTH{x_i[WIDTH-1]}}, x_i};
        mu_ext  = {{WIDTH{mu_i[WIDTH-1]}}, mu_i};
        prod    = x_ext * mu_ext;
        rounded = prod + RND;
        term_d  = WIDTH'(rounded >> QP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            term_q  <= '0;
        end else begin
            valid_q <= en_i;
            if (en_i) begin
                idx_q  <= idx_i;
                term_q <= term_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign idx_o   = idx_q;
    assign term_o  = term_q;

endmodule

// File: rtl/w_update_bank.sv
// Weight bank: walks the taps one per cycle through w_update_mac and adds each
// term into its weight. Define W_UPDATE_SAT_EN to saturate the add instead of wrapping.
module w_update_bank
    import w_update_pkg::*;
#(
    parameter int unsigned      WIDTH     = W_DEF_WIDTH,
    parameter int unsigned      QP        = W_DEF_QP,
    parameter int unsigned      TAPS      = W_DEF_TAPS,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            reset,
    w_update_bank_if.slave  bus
);
    localparam int unsigned     IDXW     = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [IDXW-1:0] LAST_TAP = IDXW'(TAPS - 1);

    w_state_e                state_q, state_d;
    logic [IDXW-1:0]         tap_q, tap_d;
    logic                    done_q, done_d;
    logic                    accept;
    logic                    mac_en;

    logic signed [WIDTH-1:0] x_q [TAPS];
    logic signed [WIDTH-1:0] mu_q;
    logic signed [WIDTH-1:0] w_q [TAPS];

    logic                    mac_valid;
    logic [IDXW-1:0]         mac_idx;
    logic signed [WIDTH-1:0] mac_term;
    logic signed [WIDTH-1:0] w_sel;
    logic signed [WIDTH-1:0] w_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        case (state_q)
            ST_IDLE: begin
                tap_d = '0;
                if (bus.start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (tap_q == LAST_TAP) begin
                    state_d = ST_DRAIN;
                    tap_d   = '0;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // done is registered from DRAIN so it lands in the first IDLE cycle,
    // which is also the cycle where a new start can be accepted.
    always_comb begin
        accept   = (state_q == ST_IDLE) && bus.start;
        mac_en   = (state_q == ST_RUN);
        done_d   = (state_q == ST_DRAIN);
        bus.busy = (state_q != ST_IDLE);
        bus.done = done_q;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mu_q <= bus.mu_error;
            for (int unsigned k = 0; k < TAPS; k++) begin
                x_q[k] <= bus.x_vec[k*WIDTH +: WIDTH];
            end
        end
    end

    w_update_mac #(
        .WIDTH (WIDTH),
        .QP    (QP),
        .IDXW  (IDXW)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .en_i    (mac_en),
        .idx_i   (tap_q),
        .x_i     (x_q[tap_q]),
        .mu_i    (mu_q),
        .valid_o (mac_valid),
        .idx_o   (mac_idx),
        .term_o  (mac_term)
    );

`ifdef W_UPDATE_SAT_EN
    logic signed [WIDTH:0] wide_sum;

    always_comb begin
        w_sel    = w_q[mac_idx];
        wide_sum = {w_sel[WIDTH-1], w_sel} + {mac_term[WIDTH-1], mac_term};
        if (wide_sum[WIDTH] != wide_sum[WIDTH-1]) begin
            w_sum = wide_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            w_sum = wide_sum[WIDTH-1:0];
        end
    end
`else
    always_comb begin
        w_sel = w_q[mac_idx];
        w_sum = w_sel + mac_term;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                w_q[k] <= RESET_VAL;
            end
        end else if (mac_valid) begin
            w_q[mac_idx] <= w_sum;
        end
    end

    always_comb begin
        bus.w_out = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            bus.w_out[k*WIDTH +: WIDTH] = w_q[k];
        end
    end

endmodule
